// File: rtl/tts_pkg.sv
// ============================================================================
// tts_pkg : shared state encoding and table-slice helper for truth_table_sweeper
// Revision 1.0
// ============================================================================
`default_nettype none

package tts_pkg;

   typedef logic [1:0] tts_state_t;

   localparam tts_state_t IDLE   = 2'd0;
   localparam tts_state_t DRIVE  = 2'd1;
   localparam tts_state_t SAMPLE = 2'd2;
   localparam tts_state_t DONE   = 2'd3;

   // LSB of the expected-output slice that belongs to vector idx
   function automatic int unsigned tts_slice_lsb(input int unsigned idx, input int unsigned n_ch);
      return idx * n_ch;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tts_settle_cnt.sv
// ============================================================================
// tts_settle_cnt : per-vector settle counter, tc high on the last settle cycle
// Revision 1.0
// ============================================================================
`default_nettype none

module tts_settle_cnt #(
   parameter int SETTLE = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int              CNT_W  = $clog2(SETTLE + 1);
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + CNT_W'(1);
   end

   assign tc = (cnt == TC_VAL);

endmodule

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// ============================================================================
// truth_table_sweeper : exhaustive truth-table sweep and compare of a DUT
// Optional mismatch log ports when TTS_LOG_EN is defined.   Revision 1.0
// ============================================================================
`default_nettype none

module truth_table_sweeper
   import tts_pkg::*;
#(
   parameter int N_IN   = 4,
   parameter int N_CH   = 2,
   parameter int SETTLE = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic [N_CH*(2**N_IN)-1:0] exp_tbl,
   input  logic [N_CH-1:0]          dut_y,
   output logic [N_IN-1:0]          vec,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [N_IN:0]            err_cnt,
   output logic [N_IN-1:0]          first_fail,
   output logic                     first_fail_vld
`ifdef TTS_LOG_EN
   ,
   output logic                     log_valid,
   output logic [N_IN-1:0]          log_idx,
   output logic [N_CH-1:0]          log_y
`endif
);

   localparam int LSB_W = (N_CH * (2**N_IN) > 1) ? $clog2(N_CH * (2**N_IN)) : 1;

   tts_state_t       state;
   logic [N_IN-1:0]  idx;
   logic             settle_tc;
   logic [LSB_W-1:0] slice_lsb;
   logic [N_CH-1:0]  exp_y;
   logic             mismatch;

   tts_settle_cnt #(
      .SETTLE (SETTLE)
   ) u_settle_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (state != DRIVE),
      .en    (state == DRIVE),
      .tc    (settle_tc)
   );

   assign slice_lsb = LSB_W'(tts_slice_lsb(32'(idx), N_CH));
   assign exp_y     = exp_tbl[slice_lsb +: N_CH];
   assign mismatch  = (dut_y != exp_y);

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         idx            <= '0;
         err_cnt        <= '0;
         first_fail     <= '0;
         first_fail_vld <= 1'b0;
      end else if (abort) begin
         // error state is kept so a board controller can inspect an aborted run
         state <= IDLE;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  idx            <= '0;
                  err_cnt        <= '0;
                  first_fail_vld <= 1'b0;
                  state          <= DRIVE;
               end
            end
            DRIVE: begin
               if (settle_tc)
                  state <= SAMPLE;
            end
            SAMPLE: begin
               if (mismatch) begin
                  err_cnt <= err_cnt + (N_IN+1)'(1);
                  if (!first_fail_vld) begin
                     first_fail     <= idx;
                     first_fail_vld <= 1'b1;
                  end
               end
               if (idx == {N_IN{1'b1}}) begin
                  state <= DONE;
               end else begin
                  idx   <= idx + N_IN'(1);
                  state <= DRIVE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef TTS_LOG_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         log_valid <= 1'b0;
         log_idx   <= '0;
         log_y     <= '0;
      end else begin
         log_valid <= 1'b0;
         if (!abort && state == SAMPLE && mismatch) begin
            log_valid <= 1'b1;
            log_idx   <= idx;
            log_y     <= dut_y;
         end
      end
   end
`endif

   assign vec  = idx;
   assign busy = (state == DRIVE) || (state == SAMPLE);
   assign done = (state == DONE);
   assign pass = (state == DONE) && (err_cnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// ============================================================================
// tb_truth_table_sweeper : scoreboard bench for truth_table_sweeper (3/1/2 and 4/2/1)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_truth_table_sweeper;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   always #5 clk = ~clk;

   // instance A: N_IN=3, N_CH=1, SETTLE=2
   logic       start_a = 1'b0, abort_a = 1'b0, stuck_a = 1'b0;
   logic [7:0] exp_a = 8'h80;
   logic [0:0] y_a;
   logic [2:0] vec_a, ff_a;
   logic [3:0] err_a;
   logic       busy_a, done_a, pass_a, ffv_a;

   // instance B: N_IN=4, N_CH=2, SETTLE=1
   logic        start_b = 1'b0;
   logic [31:0] exp_b = '0;
   logic [1:0]  y_b;
   logic [3:0]  vec_b, ff_b;
   logic [4:0]  err_b;
   logic        busy_b, done_b, pass_b, ffv_b;

   assign y_a = stuck_a ? 1'b0 : &vec_a;
   assign y_b = {^vec_b, &vec_b};

`ifdef TTS_LOG_EN
   logic       lv_a, lv_b;
   logic [2:0] li_a;
   logic [0:0] ly_a;
   logic [3:0] li_b;
   logic [1:0] ly_b;
`endif

   truth_table_sweeper #(.N_IN(3), .N_CH(1), .SETTLE(2)) u_dut_a (
      .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
      .exp_tbl(exp_a), .dut_y(y_a), .vec(vec_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .err_cnt(err_a), .first_fail(ff_a), .first_fail_vld(ffv_a)
`ifdef TTS_LOG_EN
      , .log_valid(lv_a), .log_idx(li_a), .log_y(ly_a)
`endif
   );

   truth_table_sweeper #(.N_IN(4), .N_CH(2), .SETTLE(1)) u_dut_b (
      .clk(clk), .reset(reset), .start(start_b), .abort(1'b0),
      .exp_tbl(exp_b), .dut_y(y_b), .vec(vec_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .err_cnt(err_b), .first_fail(ff_b), .first_fail_vld(ffv_b)
`ifdef TTS_LOG_EN
      , .log_valid(lv_b), .log_idx(li_b), .log_y(ly_b)
`endif
   );

   typedef struct { int err; int ff; int ffv; int pss; } sb_t;
   sb_t sb_q[$];
   int  log_q[$];   // expected log entries for instance A: {idx, y}

   int n_asserts = 0;
   int n_fail    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_asserts++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference for instance A over the first n_samp vectors; pushes expected log entries
   task automatic model_a(input logic [7:0] tbl, input bit stuck, input int n_samp, output sb_t r);
      logic [2:0] v;
      logic       y;
      r = '{0, 0, 0, 0};
      for (int i = 0; i < n_samp; i++) begin
         v = 3'(i);
         y = stuck ? 1'b0 : (v == 3'b111);
         if (y != tbl[i]) begin
            r.err++;
            if (r.ffv == 0) begin r.ff = i; r.ffv = 1; end
            log_q.push_back(i * 2 + int'(y));
         end
      end
      r.pss = (r.err == 0) ? 1 : 0;
   endtask

   task automatic start_a_pulse(input logic [7:0] tbl, input bit stuck);
      exp_a   = tbl;
      stuck_a = stuck;
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
   endtask

   task automatic run_full_a(input logic [7:0] tbl, input bit stuck, input bit pulse_busy);
      sb_t r, e;
      int  k;
      model_a(tbl, stuck, 8, r);
      sb_q.push_back(r);
      start_a_pulse(tbl, stuck);
      check("a_clr_err", 32'(err_a), 0);
      check("a_clr_ffv", 32'(ffv_a), 0);
      k = 0;
      while (!done_a && k < 100) begin
         check("a_vec", 32'(vec_a), 32'(k / 3));
         check("a_busy", 32'(busy_a), 1);
         start_a = pulse_busy && (k == 5 || k == 15);
         @(negedge clk);
         k++;
      end
      start_a = 1'b0;
      check("a_done_lat", 32'(k), 24);
      e = sb_q.pop_front();
      check("a_err_cnt", 32'(err_a), 32'(e.err));
      check("a_ffv", 32'(ffv_a), 32'(e.ffv));
      if (e.ffv != 0) check("a_first_fail", 32'(ff_a), 32'(e.ff));
      check("a_pass", 32'(pass_a), 32'(e.pss));
      check("a_busy_done", 32'(busy_a), 0);
      check("a_vec_hold", 32'(vec_a), 7);
   endtask

   task automatic run_full_b(input logic [31:0] tbl);
      sb_t r, e;
      int  k;
      logic [3:0] v;
      logic [1:0] y;
      r = '{0, 0, 0, 0};
      for (int i = 0; i < 16; i++) begin
         v = 4'(i);
         y = {^v, &v};
         if (y != tbl[2*i +: 2]) begin
            r.err++;
            if (r.ffv == 0) begin r.ff = i; r.ffv = 1; end
         end
      end
      r.pss = (r.err == 0) ? 1 : 0;
      sb_q.push_back(r);
      exp_b = tbl;
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      k = 0;
      while (!done_b && k < 100) begin
         check("b_vec", 32'(vec_b), 32'(k / 2));
         @(negedge clk);
         k++;
      end
      check("b_done_lat", 32'(k), 32);
      e = sb_q.pop_front();
      check("b_err_cnt", 32'(err_b), 32'(e.err));
      check("b_ffv", 32'(ffv_b), 32'(e.ffv));
      if (e.ffv != 0) check("b_first_fail", 32'(ff_b), 32'(e.ff));
      check("b_pass", 32'(pass_b), 32'(e.pss));
   endtask

   task automatic check_a_zero(input string tag);
      check({tag, "_vec"},  32'(vec_a),  0);
      check({tag, "_busy"}, 32'(busy_a), 0);
      check({tag, "_done"}, 32'(done_a), 0);
      check({tag, "_pass"}, 32'(pass_a), 0);
      check({tag, "_err"},  32'(err_a),  0);
      check({tag, "_ff"},   32'(ff_a),   0);
      check({tag, "_ffv"},  32'(ffv_a),  0);
`ifdef TTS_LOG_EN
      check({tag, "_lv"},   32'(lv_a),   0);
      check({tag, "_li"},   32'(li_a),   0);
      check({tag, "_ly"},   32'(ly_a),   0);
`endif
   endtask

`ifdef TTS_LOG_EN
   int log_exp;
   always @(negedge clk) begin
      if (!reset && lv_a) begin
         if (log_q.size() == 0) begin
            check("log_extra", 1, 0);
         end else begin
            log_exp = log_q.pop_front();
            check("log_idx", 32'(li_a), 32'(log_exp / 2));
            check("log_y",   32'(ly_a), 32'(log_exp % 2));
         end
      end
   end
`endif

   initial begin
      sb_t r;
      logic [31:0] tbl_b;
      logic [3:0]  v;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_a_zero("rst");
      check("rst_b_busy", 32'(busy_b), 0);
      check("rst_b_err", 32'(err_b), 0);
      reset = 1'b0;

      run_full_a(8'b1000_0000, 1'b0, 1'b0);   // AND3 correct
      run_full_a(8'b1000_0000, 1'b1, 1'b0);   // stuck-at-0
      run_full_a(8'hFF, 1'b0, 1'b0);          // wrong table

      // abort in DRIVE at cycle 10: three vectors already sampled
      model_a(8'hFF, 1'b0, 3, r);
      start_a_pulse(8'hFF, 1'b0);
      repeat (10) @(negedge clk);
      abort_a = 1'b1;
      @(negedge clk) abort_a = 1'b0;
      check("abort_busy", 32'(busy_a), 0);
      check("abort_done", 32'(done_a), 0);
      check("abort_pass", 32'(pass_a), 0);
      check("abort_err", 32'(err_a), 32'(r.err));
      check("abort_ff", 32'(ff_a), 32'(r.ff));
      check("abort_ffv", 32'(ffv_a), 32'(r.ffv));
      run_full_a(8'b1000_0000, 1'b0, 1'b0);   // restart after abort

      // abort during SAMPLE of vector 0 discards that compare
      start_a_pulse(8'hFF, 1'b0);
      repeat (2) @(negedge clk);
      abort_a = 1'b1;
      @(negedge clk) abort_a = 1'b0;
      check("abort_smp_err", 32'(err_a), 0);
      check("abort_smp_busy", 32'(busy_a), 0);

      // abort beats a simultaneous start
      @(negedge clk) begin start_a = 1'b1; abort_a = 1'b1; end
      @(negedge clk) begin start_a = 1'b0; abort_a = 1'b0; end
      check("abort_win_busy", 32'(busy_a), 0);

      run_full_a(8'b1000_0000, 1'b0, 1'b1);   // start pulses while busy ignored

      // reset mid-sweep after four sampled vectors
      model_a(8'hFF, 1'b0, 4, r);
      start_a_pulse(8'hFF, 1'b0);
      repeat (12) @(negedge clk);
      check("pre_rst_err", 32'(err_a), 32'(r.err));
      reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      check_a_zero("mid_rst");

      // 4-input, 2-channel instance
      tbl_b = '0;
      for (int i = 0; i < 16; i++) begin
         v = 4'(i);
         tbl_b[2*i +: 2] = {^v, &v};
      end
      run_full_b(tbl_b);
      tbl_b[19] = ~tbl_b[19];                 // corrupt channel 1 of vector 9
      run_full_b(tbl_b);

      repeat (3) @(negedge clk);
`ifdef TTS_LOG_EN
      check("log_left", 32'(log_q.size()), 0);
`else
      check("log_left", 32'(0), 0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
